gcn_combination_unit: RTL and testbench
=======================================

Name: gcn_combination_unit

Overview:
- Aggregation (combination) stage of the GCN pipeline; sits directly upstream of the argmax stage.
- Walks the COO edge list and, for each undirected edge (s,d), accumulates transformed-feature row T[s] into aggregate row A[d] and T[d] into A[s].
- Raises done_comb when the aggregate matrix is complete and serves aggregate rows to the argmax stage through a registered read port.

Parameters:
- FEATURE_ROWS, 6, number of graph nodes (rows of T and A).
- WEIGHT_COLS, 3, columns per row.
- DOT_PROD_WIDTH, 16, width of each element of T and A.
- NUM_EDGES, 6, number of COO entries.
- COO_ADDR_WIDTH, 3, COO memory address width.
- ROW_ADDR_WIDTH, 3, node index / row address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse from the transformation stage; begins aggregation
- coo_addr  out  COO_ADDR_WIDTH  COO memory read address
- coo_src  in  ROW_ADDR_WIDTH  source node; valid 1 cycle after coo_addr
- coo_dst  in  ROW_ADDR_WIDTH  destination node; valid 1 cycle after coo_addr
- fm_addr  out  ROW_ADDR_WIDTH  transformed-feature memory read row
- fm_data  in  WEIGHT_COLS*DOT_PROD_WIDTH  row T[fm_addr]; valid 1 cycle after fm_addr; column 0 in LSBs
- agg_rd_row  in  ROW_ADDR_WIDTH  aggregate read row (argmax side)
- agg_rd_data  out  WEIGHT_COLS*DOT_PROD_WIDTH  A[agg_rd_row], registered, 1-cycle latency
- bad_index  out  1  sticky: an edge referenced a node index ≥ FEATURE_ROWS
- done_comb  out  1  aggregation complete

Behaviour:
- Storage: A is FEATURE_ROWS × WEIGHT_COLS registers, internal to the block.
- Reset values: all A = 0, agg_rd_data = 0, coo_addr = 0, fm_addr = 0, bad_index = 0, done_comb = 0. FSM state = IDLE, edge counter = 0.
- FSM states: IDLE, CLEAR, FETCH, LATCH, ACC_DST, ACC_SRC, DONE.
- IDLE / DONE: start → CLEAR.
  - start is ignored in every other state.
  - done_comb = 1 only in DONE. It holds until the next start or reset.
- CLEAR (1 cycle):
  - All A rows ← 0; edge counter ← 0; bad_index ← 0; done_comb drops.
  - → FETCH.
- FETCH: coo_addr = edge counter. → LATCH.
- LATCH:
  - Register s = coo_src, d = coo_dst; drive fm_addr = coo_src. → ACC_DST.
- ACC_DST:
  - A[d] += fm_data elementwise; drive fm_addr = d. → ACC_SRC.
- ACC_SRC:
  - If s ≠ d: A[s] += fm_data. If s == d (self edge): no add, so the node receives T[s] exactly once.
  - Edge counter increments. If it was NUM_EDGES-1 → DONE, else → FETCH.
- Out-of-range index: if s or d ≥ FEATURE_ROWS, neither accumulation for that edge occurs and bad_index sets. The edge still consumes its 4 cycles.
- Timing:
  - 4 cycles per edge.
  - done_comb first high exactly 2 + 4*NUM_EDGES cycles after the start cycle (26 for defaults).
- Arithmetic: each element is an unsigned add, truncated modulo 2^DOT_PROD_WIDTH (wrap, no saturation). Columns are independent.
- Read port:
  - agg_rd_data ← A[agg_rd_row] every cycle.
  - agg_rd_row ≥ FEATURE_ROWS returns 0.
  - Contents are meaningful only while done_comb = 1.
- Reset mid-operation: immediate return to IDLE with all reset values. No partial A is retained.

Optional Feature:
- GCN_SELF_LOOP_EN defined:
  - A SELF state is inserted after CLEAR. It drives fm_addr = r for r = 0..FEATURE_ROWS-1 and writes A[r] = T[r] one cycle later.
  - Takes FEATURE_ROWS+1 cycles, then → FETCH.
  - Latency becomes 3 + FEATURE_ROWS + 4*NUM_EDGES (33 for defaults).
- Undefined: the SELF state does not exist and A starts at zero.

Test Plan:
- Ring graph: edges (0,1),(1,2),(2,3),(3,4),(4,5),(5,0), T[r] = {r+1, 10(r+1), 0}, start pulse → done_comb high on cycle 26; A[0] = {8,80,0}, A[3] = {8,80,0}; bad_index = 0.
- Self edge: replace edge 2 with (2,2) → A[2] = T[2]+T[1] = {5,50,0}; edge (2,2) contributes T[2] once.
- Wrap: T[1] = {0xFFFF,1,0}, T[0] = {2,0,0}, edges (0,1) plus five edges (1,0) → A[0] column 0 = 6*0xFFFF mod 2^16 = 0xFFFA; column 1 = 6.
- Bad index: edge 0 = (7,1), rest of ring → bad_index = 1; A[1] excludes T[0]; done_comb still high on cycle 26.
- Reset mid-run: assert reset on cycle 10 after start → done_comb = 0, A all zero; a new start completes the ring case correctly.
- GCN_SELF_LOOP_EN build, ring case → done_comb on cycle 33; A[0] = {9,90,0}.

Source files
------------

// File: rtl/gcn_combination_unit.sv
// gcn_combination_unit: GCN aggregation stage. Walks the COO edge list and, for every
// undirected edge (s,d), adds T[s] into A[d] and T[d] into A[s]. It raises done_comb when
// A is complete and serves rows of A to the argmax stage through a registered read port.
// Latency: 2 + 4*NUM_EDGES cycles from start to done_comb (3 + FEATURE_ROWS + 4*NUM_EDGES
// with self loops). The read port has 1-cycle latency. There is no backpressure: the
// block assumes the COO and feature memories answer one cycle after each address.
// Build option GCN_SELF_LOOP_EN: after clearing, seed A[r] = T[r] for every node.
// Ports:  clk, reset (async, active-high), start (pulse)
//         coo_addr -> / coo_src, coo_dst <-  : edge list memory, 1-cycle read
//         fm_addr  -> / fm_data <-           : transformed-feature memory, 1-cycle read
//         agg_rd_row <- / agg_rd_data ->     : aggregate read port, registered
//         bad_index (sticky), done_comb
module gcn_combination_unit #(
  parameter int FEATURE_ROWS   = 6,
  parameter int WEIGHT_COLS    = 3,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int NUM_EDGES      = 6,
  parameter int COO_ADDR_WIDTH = 3,
  parameter int ROW_ADDR_WIDTH = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  output logic [COO_ADDR_WIDTH-1:0]             coo_addr,
  input  logic [ROW_ADDR_WIDTH-1:0]             coo_src,
  input  logic [ROW_ADDR_WIDTH-1:0]             coo_dst,
  output logic [ROW_ADDR_WIDTH-1:0]             fm_addr,
  input  logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] fm_data,
  input  logic [ROW_ADDR_WIDTH-1:0]             agg_rd_row,
  output logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] agg_rd_data,
  output logic                                  bad_index,
  output logic                                  done_comb
);

  localparam int RW = WEIGHT_COLS * DOT_PROD_WIDTH;
  localparam logic [ROW_ADDR_WIDTH:0] ROWS_EXT = (ROW_ADDR_WIDTH+1)'(FEATURE_ROWS);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
`ifdef GCN_SELF_LOOP_EN
    SELF,
`endif
    FETCH,
    LATCH,
    ACC_DST,
    ACC_SRC,
    DONE
  } state_t;

  state_t                    r_state, w_next_state;
  logic [COO_ADDR_WIDTH-1:0] r_edge_cnt;
  logic [ROW_ADDR_WIDTH-1:0] r_s, r_d;
  logic                      r_edge_bad;
  logic                      r_bad_index;
  logic [RW-1:0]             r_agg [FEATURE_ROWS];
  logic [RW-1:0]             r_rd_data;
  logic [RW-1:0]             w_rd_row;
  logic [ROW_ADDR_WIDTH-1:0] w_fm_addr;
  logic                      w_last_edge;
`ifdef GCN_SELF_LOOP_EN
  // One extra bit so the counter can reach FEATURE_ROWS (the trailing write-only cycle).
  logic [ROW_ADDR_WIDTH:0]   r_self_cnt;
`endif

  function automatic logic in_range(input logic [ROW_ADDR_WIDTH-1:0] idx);
    return {1'b0, idx} < ROWS_EXT;
  endfunction

  // Column-wise unsigned add; each column wraps independently.
  function automatic logic [RW-1:0] add_row(input logic [RW-1:0] a, input logic [RW-1:0] b);
    logic [RW-1:0] sum;
    sum = '0;
    for (int c = 0; c < WEIGHT_COLS; c++) begin
      sum[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH] =
        a[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH] + b[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH];
    end
    return sum;
  endfunction

  assign w_last_edge = (r_edge_cnt == COO_ADDR_WIDTH'(NUM_EDGES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_fm_addr    = '0;
    case (r_state)
      IDLE, DONE: if (start) w_next_state = CLEAR;
`ifdef GCN_SELF_LOOP_EN
      CLEAR:      w_next_state = SELF;
      SELF: begin
        w_fm_addr = r_self_cnt[ROW_ADDR_WIDTH-1:0];
        if (r_self_cnt == ROWS_EXT) w_next_state = FETCH;
      end
`else
      CLEAR:      w_next_state = FETCH;
`endif
      FETCH:      w_next_state = LATCH;
      LATCH: begin
        w_fm_addr    = coo_src;
        w_next_state = ACC_DST;
      end
      ACC_DST: begin
        w_fm_addr    = r_d;
        w_next_state = ACC_SRC;
      end
      ACC_SRC:    w_next_state = w_last_edge ? DONE : FETCH;
      default:    w_next_state = IDLE;
    endcase
  end

  // fm_data during ACC_DST is T[s]; during ACC_SRC it is T[d].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_edge_cnt  <= '0;
      r_s         <= '0;
      r_d         <= '0;
      r_edge_bad  <= 1'b0;
      r_bad_index <= 1'b0;
      for (int r = 0; r < FEATURE_ROWS; r++) r_agg[r] <= '0;
`ifdef GCN_SELF_LOOP_EN
      r_self_cnt  <= '0;
`endif
    end else begin
      case (r_state)
        CLEAR: begin
          r_edge_cnt  <= '0;
          r_bad_index <= 1'b0;
          for (int r = 0; r < FEATURE_ROWS; r++) r_agg[r] <= '0;
`ifdef GCN_SELF_LOOP_EN
          r_self_cnt  <= '0;
`endif
        end
`ifdef GCN_SELF_LOOP_EN
        SELF: begin
          r_self_cnt <= r_self_cnt + (ROW_ADDR_WIDTH+1)'(1);
          // Data returned now belongs to the row addressed last cycle.
          for (int r = 0; r < FEATURE_ROWS; r++)
            if (r_self_cnt == (ROW_ADDR_WIDTH+1)'(r + 1)) r_agg[r] <= fm_data;
        end
`endif
        LATCH: begin
          r_s        <= coo_src;
          r_d        <= coo_dst;
          r_edge_bad <= !(in_range(coo_src) && in_range(coo_dst));
          if (!(in_range(coo_src) && in_range(coo_dst))) r_bad_index <= 1'b1;
        end
        ACC_DST: begin
          for (int r = 0; r < FEATURE_ROWS; r++)
            if (!r_edge_bad && r_d == ROW_ADDR_WIDTH'(r)) r_agg[r] <= add_row(r_agg[r], fm_data);
        end
        ACC_SRC: begin
          // Self edge: A[s] already received T[s] in ACC_DST, so skip the second add.
          for (int r = 0; r < FEATURE_ROWS; r++)
            if (!r_edge_bad && r_s != r_d && r_s == ROW_ADDR_WIDTH'(r))
              r_agg[r] <= add_row(r_agg[r], fm_data);
          r_edge_cnt <= r_edge_cnt + COO_ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rd_row = '0;
    for (int r = 0; r < FEATURE_ROWS; r++)
      if (agg_rd_row == ROW_ADDR_WIDTH'(r)) w_rd_row = r_agg[r];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rd_data <= '0;
    else       r_rd_data <= w_rd_row;
  end

  assign coo_addr    = r_edge_cnt;
  assign fm_addr     = w_fm_addr;
  assign agg_rd_data = r_rd_data;
  assign bad_index   = r_bad_index;
  assign done_comb   = (r_state == DONE);

endmodule

// File: tb/tb_gcn_combination_unit.sv
module tb_gcn_combination_unit;
  localparam int RAW = 3;
  localparam int CAW = 3;
  localparam int RW  = 48;
`ifdef GCN_SELF_LOOP_EN
  localparam int SELF = 1;
  localparam int LAT  = 33;
`else
  localparam int SELF = 0;
  localparam int LAT  = 26;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [CAW-1:0] coo_addr;
  logic [RAW-1:0] coo_src, coo_dst;
  logic [RAW-1:0] fm_addr;
  logic [RW-1:0]  fm_data;
  logic [RAW-1:0] agg_rd_row;
  logic [RW-1:0]  agg_rd_data;
  logic           bad_index;
  logic           done_comb;

  int checks = 0;
  int errors = 0;

  logic [RAW-1:0] src_mem [8];
  logic [RAW-1:0] dst_mem [8];
  logic [RW-1:0]  t_mem   [8];

  gcn_combination_unit dut (
    .clk(clk), .reset(reset), .start(start),
    .coo_addr(coo_addr), .coo_src(coo_src), .coo_dst(coo_dst),
    .fm_addr(fm_addr), .fm_data(fm_data),
    .agg_rd_row(agg_rd_row), .agg_rd_data(agg_rd_data),
    .bad_index(bad_index), .done_comb(done_comb)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: data one cycle after the address.
  always @(posedge clk) begin
    coo_src <= src_mem[coo_addr];
    coo_dst <= dst_mem[coo_addr];
    fm_data <= t_mem[fm_addr];
  end

  function automatic logic [RW-1:0] mk(input int c0, input int c1, input int c2);
    logic [15:0] a, b, c;
    a = c0[15:0]; b = c1[15:0]; c = c2[15:0];
    return {c, b, a};
  endfunction

  task automatic load_ring();
    for (int r = 0; r < 8; r++) t_mem[r] = mk(r + 1, 10 * (r + 1), 0);
    for (int e = 0; e < 8; e++) begin
      src_mem[e] = RAW'(e);
      dst_mem[e] = RAW'((e + 1) % 6);
    end
  endtask

  // Called at a negedge; returns the cycle number (start cycle = 0) of first done_comb.
  task automatic run(output int cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done_comb !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic read_row(input int r, output logic [RW-1:0] v);
    agg_rd_row = RAW'(r);
    @(negedge clk);
    v = agg_rd_data;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; agg_rd_row = '0;
    load_ring();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({done_comb, bad_index, coo_addr, fm_addr, agg_rd_data} !== '0) begin
      $display("FAIL reset_values: got done=%b bad=%b coo_addr=%0d fm_addr=%0d rd=%h, want all 0",
               done_comb, bad_index, coo_addr, fm_addr, agg_rd_data);
      errors++;
    end
  endtask

  task automatic test_ring();
    int cyc;
    logic [RW-1:0] v;
    int rows [4] = '{0, 3, 1, 5};
    logic [RW-1:0] exp [4];
    exp[0] = mk(8 + SELF*1, 80 + SELF*10, 0);
    exp[1] = mk(8 + SELF*4, 80 + SELF*40, 0);
    exp[2] = mk(4 + SELF*2, 40 + SELF*20, 0);
    exp[3] = mk(6 + SELF*6, 60 + SELF*60, 0);
    load_ring();
    run(cyc);
    checks++;
    if (cyc !== LAT) begin
      $display("FAIL ring_latency: done_comb first high on cycle %0d, want %0d", cyc, LAT);
      errors++;
    end
    checks++;
    if (bad_index !== 1'b0) begin
      $display("FAIL ring_bad_index: got %b want 0", bad_index);
      errors++;
    end
    for (int i = 0; i < 4; i++) begin
      read_row(rows[i], v);
      checks++;
      if (v !== exp[i]) begin
        $display("FAIL ring_A%0d: got %h want %h", rows[i], v, exp[i]);
        errors++;
      end
    end
    // done_comb holds while idle in DONE.
    repeat (3) @(negedge clk);
    checks++;
    if (done_comb !== 1'b1) begin
      $display("FAIL done_hold: got %b want 1", done_comb);
      errors++;
    end
  endtask

  task automatic test_self_edge();
    int cyc;
    logic [RW-1:0] v;
    logic [RW-1:0] e2, e3;
    load_ring();
    src_mem[2] = 3'd2; dst_mem[2] = 3'd2;
    e2 = mk(5 + SELF*3, 50 + SELF*30, 0);
    e3 = mk(5 + SELF*4, 50 + SELF*40, 0);
    run(cyc);
    checks++;
    if (cyc !== LAT) begin
      $display("FAIL self_edge_latency: got %0d want %0d", cyc, LAT);
      errors++;
    end
    read_row(2, v);
    checks++;
    if (v !== e2) begin
      $display("FAIL self_edge_A2: got %h want %h", v, e2);
      errors++;
    end
    read_row(3, v);
    checks++;
    if (v !== e3) begin
      $display("FAIL self_edge_A3: got %h want %h", v, e3);
      errors++;
    end
  endtask

  task automatic test_wrap();
    int cyc;
    logic [RW-1:0] v;
    logic [RW-1:0] e0, e1;
    load_ring();
    t_mem[0] = mk(2, 0, 0);
    t_mem[1] = mk(16'hFFFF, 1, 0);
    src_mem[0] = 3'd0; dst_mem[0] = 3'd1;
    for (int e = 1; e < 6; e++) begin
      src_mem[e] = 3'd1; dst_mem[e] = 3'd0;
    end
    e0 = (SELF != 0) ? mk(16'hFFFC, 6, 0) : mk(16'hFFFA, 6, 0);
    e1 = (SELF != 0) ? mk(16'h000B, 1, 0) : mk(12, 0, 0);
    run(cyc);
    read_row(0, v);
    checks++;
    if (v !== e0) begin
      $display("FAIL wrap_A0: got %h want %h", v, e0);
      errors++;
    end
    read_row(1, v);
    checks++;
    if (v !== e1) begin
      $display("FAIL wrap_A1: got %h want %h", v, e1);
      errors++;
    end
  endtask

  task automatic test_bad_index();
    int cyc;
    logic [RW-1:0] v;
    logic [RW-1:0] e0, e1;
    load_ring();
    src_mem[0] = 3'd7; dst_mem[0] = 3'd1;
    e0 = mk(6 + SELF*1, 60 + SELF*10, 0);
    e1 = mk(3 + SELF*2, 30 + SELF*20, 0);
    run(cyc);
    checks++;
    if (cyc !== LAT) begin
      $display("FAIL bad_latency: got %0d want %0d", cyc, LAT);
      errors++;
    end
    checks++;
    if (bad_index !== 1'b1) begin
      $display("FAIL bad_flag: got %b want 1", bad_index);
      errors++;
    end
    read_row(1, v);
    checks++;
    if (v !== e1) begin
      $display("FAIL bad_A1: got %h want %h", v, e1);
      errors++;
    end
    read_row(0, v);
    checks++;
    if (v !== e0) begin
      $display("FAIL bad_A0: got %h want %h", v, e0);
      errors++;
    end
    read_row(7, v);
    checks++;
    if (v !== '0) begin
      $display("FAIL read_out_of_range: got %h want 0", v);
      errors++;
    end
    // A clean run from DONE must clear the sticky flag.
    load_ring();
    run(cyc);
    checks++;
    if (bad_index !== 1'b0) begin
      $display("FAIL bad_clear_on_restart: got %b want 0", bad_index);
      errors++;
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    logic [RW-1:0] v;
    load_ring();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (done_comb !== 1'b0 || bad_index !== 1'b0 || agg_rd_data !== '0) begin
      $display("FAIL midrun_reset_outputs: got done=%b bad=%b rd=%h want 0 0 0",
               done_comb, bad_index, agg_rd_data);
      errors++;
    end
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 6; r++) begin
      read_row(r, v);
      checks++;
      if (v !== '0) begin
        $display("FAIL midrun_reset_A%0d: got %h want 0", r, v);
        errors++;
      end
    end
    checks++;
    if (done_comb !== 1'b0) begin
      $display("FAIL midrun_idle_done: got %b want 0", done_comb);
      errors++;
    end
    run(cyc);
    checks++;
    if (cyc !== LAT) begin
      $display("FAIL rerun_latency: got %0d want %0d", cyc, LAT);
      errors++;
    end
    read_row(0, v);
    checks++;
    if (v !== mk(8 + SELF, 80 + SELF*10, 0)) begin
      $display("FAIL rerun_A0: got %h want %h", v, mk(8 + SELF, 80 + SELF*10, 0));
      errors++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_ring();
    test_self_edge();
    test_wrap();
    test_bad_index();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
